// File: rtl/data_ram_ws_if.sv
// Data-bus request/response bundle between the MCU core (master) and the data RAM (slave).
interface data_ram_ws_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wData;
    logic [2:0]  func3;
    logic [31:0] rData;
    logic        ready;
    logic        err;

    modport master (
        output req, we, addr, wData, func3,
        input  rData, ready, err
    );

    modport slave (
        input  req, we, addr, wData, func3,
        output rData, ready, err
    );
endinterface

// File: rtl/data_ram_ws.sv
// Word-organised data RAM with programmable wait states, own address-window decode,
// byte/half/word store masking and load extension; bad accesses get a one-cycle err.
module data_ram_ws #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic          clk,
    input  logic          reset,
    data_ram_ws_if.slave  bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LAST  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic legal;
        logic misal;
        if (we) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
        misal = ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
        return !legal || misal;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lane +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    logic [31:0]   mem_q [DEPTH_WORDS];

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          ready_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic          we_q;
    logic [2:0]    func3_q;
    logic [1:0]    lane_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          bad_q;

    logic [31:0]   off_d;
    logic [AW-1:0] idx_d;
    logic          bad_d;
    logic [3:0]    be_d;
    logic [31:0]   wr_d;

    // Decode of the live request; only meaningful while IDLE sees req.
    always_comb begin
        off_d = bus.addr - BASE_ADDR;
        idx_d = off_d[AW+1:2];
        bad_d = access_bad(bus.we, bus.func3, bus.addr[1:0]) || (off_d >= WIN_BYTES);
        be_d  = store_be(func3_q[1:0], lane_q);
        wr_d  = store_data(func3_q[1:0], wdata_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        func3_q <= bus.func3;
                        lane_q  <= bus.addr[1:0];
                        idx_q   <= idx_d;
                        wdata_q <= bus.wData;
                        bad_q   <= bad_d;
                        if (bad_d) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            rdata_q <= bus.we ? 32'd0
                                              : load_ext(mem_q[idx_d], bus.func3, bus.addr[1:0]);
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'd0;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        rdata_q <= we_q ? 32'd0 : load_ext(mem_q[idx_q], func3_q, lane_q);
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Store commits on the edge that ends RESP, so a reset there still aborts it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_RESP) && we_q && !bad_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_d[b]) mem_q[idx_q][8*b +: 8] <= wr_d[8*b +: 8];
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rData = rdata_q;

endmodule
